// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command decoder slice.
// Holds FSM state encodings, command-number codes reported on cmd_nr, the
// bit positions of the ICW/OCW fields the decoder looks at, and a helper
// that picks the state following ICW2.
package pic_pkg;

  // Initialisation / operating states
  localparam logic [2:0] ST_UNINIT    = 3'd0;
  localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  // cmd_nr codes (meaning depends on cmd_type)
  localparam logic [1:0] NR_ICW1 = 2'd0;
  localparam logic [1:0] NR_ICW2 = 2'd1;
  localparam logic [1:0] NR_ICW3 = 2'd2;
  localparam logic [1:0] NR_ICW4 = 2'd3;
  localparam logic [1:0] NR_OCW1 = 2'd0;
  localparam logic [1:0] NR_OCW2 = 2'd1;
  localparam logic [1:0] NR_OCW3 = 2'd2;

  // ICW field positions
  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned ICW1_SEL  = 4;
  localparam int unsigned ICW4_AEOI = 1;

  // OCW field positions
  localparam int unsigned OCW_SEL3  = 3;
  localparam int unsigned OCW3_RIS  = 0;
  localparam int unsigned OCW3_RR   = 1;
  localparam int unsigned OCW3_SMM  = 5;
  localparam int unsigned OCW3_ESMM = 6;

  // ICW3 is only expected in cascade mode; ICW4 only when ICW1 asked for it.
  function automatic logic [2:0] after_icw2(input logic sngl, input logic ic4);
    if (!sngl)
      return ST_WAIT_ICW3;
    else if (ic4)
      return ST_WAIT_ICW4;
    else
      return ST_READY;
  endfunction

endpackage

// File: rtl/pic_bus_sampler.sv
// CPU bus front end for the PIC command decoder.
// Registers the bus strobes, address bit and write data every cycle and
// flags the cycle in which a write or read strobe is released while the
// chip was selected.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cs_n, rd_n, wr_n  raw active-low bus strobes
//   a0, din           raw address bit and write data
//   a0_q, din_q       sampled address bit / data, valid during wr_done
//   wr_done           write strobe released this cycle with chip selected
//   rd_done           read strobe released this cycle with chip selected
module pic_bus_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       a0_q,
  output logic [7:0] din_q,
  output logic       wr_done,
  output logic       rd_done
);

  logic wr_q;
  logic rd_q;
  logic cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b1;
      rd_q  <= 1'b1;
      cs_q  <= 1'b0;
      a0_q  <= 1'b0;
      din_q <= 8'h00;
    end else begin
      wr_q  <= wr_n;
      rd_q  <= rd_n;
      cs_q  <= cs_n;
      a0_q  <= a0;
      din_q <= din;
    end
  end

  // Completion is the rising edge of the strobe; the select seen is the one
  // sampled while the strobe was still low.
  assign wr_done = wr_n & ~wr_q & ~cs_q;
  assign rd_done = rd_n & ~rd_q & ~cs_q;

endmodule

// File: rtl/pic_cmd_decoder.sv
// PIC command decoder: decodes ICW1-4 / OCW1-3 writes from the CPU bus,
// tracks the initialisation sequence, holds the configuration registers
// and the interrupt mask, and returns IRR/ISR/IMR bytes on reads.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cs_n, rd_n, wr_n, a0, din   CPU bus
//   dout, dout_oe               registered read data, read-data enable
//   irr_in, isr_in              request / in-service registers
//   cmd_valid/type/nr/data      one-cycle report of each accepted command
//   imr                         interrupt mask register
//   vec_base, cascade           ICW2[7:3], ICW3
//   ltim, sngl, ic4, aeoi, smm  configuration flags
//   init_done                   initialisation complete
module pic_cmd_decoder
  import pic_pkg::*;
#(
  parameter int MASK_BYTES = 1,
  parameter int IRQ_W      = 8 * MASK_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             a0,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             dout_oe,
  input  logic [IRQ_W-1:0] irr_in,
  input  logic [IRQ_W-1:0] isr_in,
  output logic             cmd_valid,
  output logic             cmd_type,
  output logic [1:0]       cmd_nr,
  output logic [7:0]       cmd_data,
  output logic [IRQ_W-1:0] imr,
  output logic [4:0]       vec_base,
  output logic             ltim,
  output logic             sngl,
  output logic             ic4,
  output logic             aeoi,
  output logic             smm,
  output logic [7:0]       cascade,
  output logic             init_done
);

  logic       a0_q;
  logic [7:0] din_q;
  logic       wr_done;
  logic       rd_done;

  pic_bus_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .a0      (a0),
    .din     (din),
    .a0_q    (a0_q),
    .din_q   (din_q),
    .wr_done (wr_done),
    .rd_done (rd_done)
  );

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       wptr;
  logic       rptr;
  logic       rsel;          // 0 = IRR, 1 = ISR on A0=0 reads
  logic       accept;
  logic       acc_type;
  logic [1:0] acc_nr;
  logic [7:0] rd_byte;

  // Write decode: ICW1 restarts initialisation from any state; everything
  // else is interpreted according to where the sequence currently is.
  always_comb begin
    accept    = 1'b0;
    acc_type  = 1'b0;
    acc_nr    = 2'd0;
    state_nxt = state;
    if (wr_done) begin
      if (!a0_q && din_q[ICW1_SEL]) begin
        accept    = 1'b1;
        acc_type  = 1'b1;
        acc_nr    = NR_ICW1;
        state_nxt = ST_WAIT_ICW2;
      end else begin
        case (state)
          ST_WAIT_ICW2: if (a0_q) begin
            accept    = 1'b1;
            acc_type  = 1'b1;
            acc_nr    = NR_ICW2;
            state_nxt = after_icw2(sngl, ic4);
          end
          ST_WAIT_ICW3: if (a0_q) begin
            accept    = 1'b1;
            acc_type  = 1'b1;
            acc_nr    = NR_ICW3;
            state_nxt = ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: if (a0_q) begin
            accept    = 1'b1;
            acc_type  = 1'b1;
            acc_nr    = NR_ICW4;
            state_nxt = ST_READY;
          end
          ST_READY: begin
            accept = 1'b1;
            if (a0_q)
              acc_nr = NR_OCW1;
            else if (din_q[OCW_SEL3])
              acc_nr = NR_OCW3;
            else
              acc_nr = NR_OCW2;
          end
          default: ;
        endcase
      end
    end
  end

  // Read byte: with two mask bytes the read pointer walks low then high.
  always_comb begin
    rd_byte = 8'h00;
    if (a0) begin
      if (MASK_BYTES == 2 && rptr)
        rd_byte = imr[IRQ_W-1 -: 8];
      else
        rd_byte = imr[7:0];
    end else if (rsel) begin
      if (MASK_BYTES == 2 && rptr)
        rd_byte = isr_in[IRQ_W-1 -: 8];
      else
        rd_byte = isr_in[7:0];
    end else begin
      if (MASK_BYTES == 2 && rptr)
        rd_byte = irr_in[IRQ_W-1 -: 8];
      else
        rd_byte = irr_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_UNINIT;
      cmd_valid <= 1'b0;
      cmd_type  <= 1'b0;
      cmd_nr    <= 2'd0;
      cmd_data  <= 8'h00;
      imr       <= '0;
      vec_base  <= 5'd0;
      cascade   <= 8'h00;
      ltim      <= 1'b0;
      sngl      <= 1'b0;
      ic4       <= 1'b0;
      aeoi      <= 1'b0;
      smm       <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      rsel      <= 1'b0;
      dout      <= 8'h00;
    end else begin
      state     <= state_nxt;
      cmd_valid <= accept;
      dout      <= rd_byte;

      if (wr_done)
        rptr <= 1'b0;
      else if (rd_done && MASK_BYTES == 2)
        rptr <= ~rptr;

      // Any A0=0 write restarts the OCW1 mask byte sequence.
      if (wr_done && !a0_q)
        wptr <= 1'b0;

      if (accept) begin
        cmd_type <= acc_type;
        cmd_nr   <= acc_nr;
        cmd_data <= din_q;
        if (acc_type) begin
          case (acc_nr)
            NR_ICW1: begin
              ltim <= din_q[ICW1_LTIM];
              sngl <= din_q[ICW1_SNGL];
              ic4  <= din_q[ICW1_IC4];
              imr  <= '0;
              aeoi <= 1'b0;
              smm  <= 1'b0;
              rsel <= 1'b0;
            end
            NR_ICW2: vec_base <= din_q[7:3];
            NR_ICW3: cascade  <= din_q;
            default: aeoi     <= din_q[ICW4_AEOI];
          endcase
        end else begin
          case (acc_nr)
            NR_OCW1: begin
              if (MASK_BYTES == 2 && wptr)
                imr[IRQ_W-1 -: 8] <= din_q;
              else
                imr[7:0] <= din_q;
              if (MASK_BYTES == 2)
                wptr <= ~wptr;
            end
            NR_OCW3: begin
              if (din_q[OCW3_RR])
                rsel <= din_q[OCW3_RIS];
              if (din_q[OCW3_ESMM])
                smm <= din_q[OCW3_SMM];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign dout_oe   = ~cs_n & ~rd_n & wr_n;
  assign init_done = (state == ST_READY);

endmodule

// File: tb/tb_pic_cmd_decoder.sv
// Self-checking bench for pic_cmd_decoder (two mask bytes).
// Expected commands are queued when a write is issued; a monitor pops and
// compares each cmd_valid pulse. Register and read-data values are checked
// directly against hand-computed constants.
module tb_pic_cmd_decoder;

  localparam int MB = 2;
  localparam int IW = 8 * MB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          rd_n = 1'b1;
  logic          wr_n = 1'b1;
  logic          a0 = 1'b0;
  logic [7:0]    din = 8'h00;
  logic [7:0]    dout;
  logic          dout_oe;
  logic [IW-1:0] irr_in = '0;
  logic [IW-1:0] isr_in = '0;
  logic          cmd_valid;
  logic          cmd_type;
  logic [1:0]    cmd_nr;
  logic [7:0]    cmd_data;
  logic [IW-1:0] imr;
  logic [4:0]    vec_base;
  logic          ltim, sngl, ic4, aeoi, smm;
  logic [7:0]    cascade;
  logic          init_done;

  pic_cmd_decoder #(.MASK_BYTES(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a0        (a0),
    .din       (din),
    .dout      (dout),
    .dout_oe   (dout_oe),
    .irr_in    (irr_in),
    .isr_in    (isr_in),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_nr    (cmd_nr),
    .cmd_data  (cmd_data),
    .imr       (imr),
    .vec_base  (vec_base),
    .ltim      (ltim),
    .sngl      (sngl),
    .ic4       (ic4),
    .aeoi      (aeoi),
    .smm       (smm),
    .cascade   (cascade),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       t;
    logic [1:0] nr;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every cmd_valid pulse must match the oldest queued command.
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cmd: got type=%0d nr=%0d data=0x%0h expected none",
                 cmd_type, cmd_nr, cmd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({cmd_type, cmd_nr, cmd_data} !== e) begin
          failures++;
          $display("FAIL cmd: got type=%0d nr=%0d data=0x%0h expected type=%0d nr=%0d data=0x%0h",
                   cmd_type, cmd_nr, cmd_data, e.t, e.nr, e.d);
        end
      end
    end
  end

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
    @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr_exp(input logic a, input logic [7:0] d, input logic t, input logic [1:0] nr);
    exp_q.push_back({t, nr, d});
    bus_wr(a, d);
  endtask

  task automatic bus_rd(input logic a, input logic [7:0] req, input string name);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; a0 = a;
    @(negedge clk);
    chk({name, "_oe"}, {31'd0, dout_oe}, 32'd1);
    chk(name, {24'd0, dout}, {24'd0, req});
    rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_imr", {16'd0, imr}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Writes before ICW1 are ignored
    bus_wr(1'b1, 8'hFF);
    bus_wr(1'b0, 8'h20);
    chk("pre_icw1_imr", {16'd0, imr}, 32'd0);
    chk("pre_icw1_init", {31'd0, init_done}, 32'd0);

    // Single mode with ICW4: ICW3 skipped
    wr_exp(1'b0, 8'h13, 1'b1, 2'd0);
    chk("icw1_flags", {29'd0, ltim, sngl, ic4}, 32'h3);
    wr_exp(1'b1, 8'h20, 1'b1, 2'd1);
    chk("icw2_init", {31'd0, init_done}, 32'd0);
    bus_wr(1'b0, 8'h05);                       // ignored while waiting for ICW4
    wr_exp(1'b1, 8'h03, 1'b1, 2'd3);
    chk("icw4_init_done", {31'd0, init_done}, 32'd1);
    chk("vec_base", {27'd0, vec_base}, 32'h04);
    chk("aeoi", {31'd0, aeoi}, 32'd1);

    // Two-byte mask load and readback
    wr_exp(1'b1, 8'hAA, 1'b0, 2'd0);
    wr_exp(1'b1, 8'h55, 1'b0, 2'd0);
    chk("imr16", {16'd0, imr}, 32'h55AA);
    bus_rd(1'b1, 8'hAA, "imr_rd0");
    bus_rd(1'b1, 8'h55, "imr_rd1");
    bus_rd(1'b1, 8'hAA, "imr_rd2");

    // Read select via OCW3
    isr_in = 16'h0080;
    irr_in = 16'h1234;
    wr_exp(1'b0, 8'h0B, 1'b0, 2'd2);
    bus_rd(1'b0, 8'h80, "isr_rd");
    wr_exp(1'b0, 8'h0A, 1'b0, 2'd2);
    bus_rd(1'b0, 8'h34, "irr_rd0");
    bus_rd(1'b0, 8'h12, "irr_rd1");
    wr_exp(1'b0, 8'h68, 1'b0, 2'd2);
    chk("smm_set", {31'd0, smm}, 32'd1);
    wr_exp(1'b0, 8'h20, 1'b0, 2'd1);
    chk("ocw2_imr", {16'd0, imr}, 32'h55AA);

    // Write priority on dout_oe; strobes ignored once chip select drops
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h00;
    #1 chk("oe_wr_prio", {31'd0, dout_oe}, 32'd0);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cs_ignored_imr", {16'd0, imr}, 32'h55AA);

    // Cascade mode without ICW4
    wr_exp(1'b0, 8'h10, 1'b1, 2'd0);
    chk("icw1_clr_imr", {16'd0, imr}, 32'd0);
    chk("icw1_clr_aeoi_smm", {30'd0, aeoi, smm}, 32'd0);
    wr_exp(1'b1, 8'h08, 1'b1, 2'd1);
    chk("wait_icw3_init", {31'd0, init_done}, 32'd0);
    wr_exp(1'b1, 8'h04, 1'b1, 2'd2);
    chk("icw3_init_done", {31'd0, init_done}, 32'd1);
    chk("cascade", {24'd0, cascade}, 32'h04);
    chk("sngl0", {31'd0, sngl}, 32'd0);
    chk("vec_base2", {27'd0, vec_base}, 32'h01);

    // Reset in WAIT_ICW3 with a write completing in the reset cycle
    wr_exp(1'b0, 8'h10, 1'b1, 2'd0);
    wr_exp(1'b1, 8'h08, 1'b1, 2'd1);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h04;
    @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_init", {31'd0, init_done}, 32'd0);
    chk("rst_mid_cascade", {24'd0, cascade}, 32'd0);
    chk("rst_mid_vec", {27'd0, vec_base}, 32'd0);
    chk("rst_mid_flags", {27'd0, ltim, sngl, ic4, aeoi, smm}, 32'd0);
    chk("rst_mid_cmd", {20'd0, cmd_valid, cmd_type, cmd_nr, cmd_data}, 32'd0);
    bus_wr(1'b1, 8'h04);                       // UNINIT: ignored
    chk("uninit_icw3_ignored", {31'd0, init_done}, 32'd0);

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
